sd_enmux_n: RTL and testbench

- Parametrised width-narrowing serializer on the srdy/drdy handshake.
- Accepts one `width`-bit word on the consumer (c_) side and emits it as `ratio` beats of `width/ratio` bits on the producer (p_) side.
- Marks the final beat with p_last.
- Generalises the fixed 2:1 enmux to any integer ratio, selectable beat order and an optional zero-bubble mode.
- Sits between a wide pipeline stage and a narrow link; paired downstream with a matching deserializer.

---
 rtl/sd_enmux_n.sv | 96 +++++++++
 tb/tb_sd_enmux_n.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_enmux_n.sv
// sd_enmux_n: width-narrowing srdy/drdy serializer; one c_data_i word leaves as `ratio` beats on p_data_o.
// Optional macro SD_ENMUX_N_ZERO_BUBBLE_EN accepts the next word on the final-beat transfer.
//
// state | meaning
// IDLE  | nothing held; c_drdy_o high, p_srdy_o low
// BUSY  | hold_q being emitted, beat index cnt_q presented on p_data_o
`default_nettype none

module sd_enmux_n #(
  parameter int width     = 8,
  parameter int ratio     = 2,
  parameter int msb_first = 0
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     c_srdy_i,
  output logic                     c_drdy_o,
  input  logic [width-1:0]         c_data_i,
  output logic                     p_srdy_o,
  input  logic                     p_drdy_i,
  output logic [width/ratio-1:0]   p_data_o,
  output logic                     p_last_o
);

  localparam int BW = width / ratio;
  localparam int CW = $clog2(ratio);
  localparam logic [CW-1:0] CNT_LAST = CW'(ratio - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [width-1:0] hold_q, hold_d;
  logic [CW-1:0]    slice_idx;
  logic [BW-1:0]    slice [ratio];
  logic             busy;
  logic             last_beat;
  logic             beat_xfer;
  logic             word_acc;

  for (genvar g = 0; g < ratio; g++) begin : g_slice
    assign slice[g] = hold_q[g*BW +: BW];
  end

  always_comb begin
    busy      = (state_q == BUSY);
    last_beat = busy & (cnt_q == CNT_LAST);
    slice_idx = (msb_first != 0) ? (CNT_LAST - cnt_q) : cnt_q;
    p_srdy_o  = busy;
    p_last_o  = last_beat;
    p_data_o  = slice[slice_idx];
`ifdef SD_ENMUX_N_ZERO_BUBBLE_EN
    // Refill path: combinational through p_drdy_i by design.
    c_drdy_o  = ~busy | (last_beat & p_drdy_i);
`else
    c_drdy_o  = ~busy;
`endif
    beat_xfer = busy & p_drdy_i;
    word_acc  = c_srdy_i & c_drdy_o;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    if (beat_xfer) begin
      if (last_beat) begin
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // A word accepted alongside the final beat overrides the return to IDLE.
    if (word_acc) begin
      hold_d  = c_data_i;
      cnt_d   = '0;
      state_d = BUSY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sd_enmux_n.sv
// tb_sd_enmux_n: directed vectors, hand sequences and random handshake scoreboard for sd_enmux_n.
`timescale 1ns/1ps

module tb_sd_enmux_n;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // a: 8/2 lsb-first, b: 32/4 lsb-first, c: 32/8 msb-first, d: 32/4 msb-first
  logic a_cs, a_cd, a_ps, a_pd, a_pl;
  logic [7:0]  a_cdat;
  logic [3:0]  a_pdat;
  logic b_cs, b_cd, b_ps, b_pd, b_pl;
  logic [31:0] b_cdat;
  logic [7:0]  b_pdat;
  logic c_cs, c_cd, c_ps, c_pd, c_pl;
  logic [31:0] c_cdat;
  logic [3:0]  c_pdat;
  logic d_cs, d_cd, d_ps, d_pd, d_pl;
  logic [31:0] d_cdat;
  logic [7:0]  d_pdat;

  sd_enmux_n #(.width(8), .ratio(2), .msb_first(0)) u_a (
    .clk_i(clk), .reset_i(reset), .c_srdy_i(a_cs), .c_drdy_o(a_cd), .c_data_i(a_cdat),
    .p_srdy_o(a_ps), .p_drdy_i(a_pd), .p_data_o(a_pdat), .p_last_o(a_pl));
  sd_enmux_n #(.width(32), .ratio(4), .msb_first(0)) u_b (
    .clk_i(clk), .reset_i(reset), .c_srdy_i(b_cs), .c_drdy_o(b_cd), .c_data_i(b_cdat),
    .p_srdy_o(b_ps), .p_drdy_i(b_pd), .p_data_o(b_pdat), .p_last_o(b_pl));
  sd_enmux_n #(.width(32), .ratio(8), .msb_first(1)) u_c (
    .clk_i(clk), .reset_i(reset), .c_srdy_i(c_cs), .c_drdy_o(c_cd), .c_data_i(c_cdat),
    .p_srdy_o(c_ps), .p_drdy_i(c_pd), .p_data_o(c_pdat), .p_last_o(c_pl));
  sd_enmux_n #(.width(32), .ratio(4), .msb_first(1)) u_d (
    .clk_i(clk), .reset_i(reset), .c_srdy_i(d_cs), .c_drdy_o(d_cd), .c_data_i(d_cdat),
    .p_srdy_o(d_ps), .p_drdy_i(d_pd), .p_data_o(d_pdat), .p_last_o(d_pl));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Random-phase scoreboard: accepted words queued, beats checked against reassembly order.
  logic [31:0] qa[$], qb[$], qc[$];
  int bidx[3];
  int done[3];

  task automatic sb(input int i, input logic cs, input logic cdr, input logic [31:0] cd,
                    input logic ps, input logic pd, input logic [31:0] pdv, input logic pl);
    int r, bw, k, qs;
    logic msb;
    logic [31:0] w, e;
    r   = (i == 0) ? 2 : (i == 1) ? 4 : 8;
    bw  = (i == 1) ? 8 : 4;
    msb = (i == 2);
    qs  = (i == 0) ? qa.size() : (i == 1) ? qb.size() : qc.size();
    if (ps && pd) begin
      if (qs == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rnd_spurious_beat inst %0d: got beat %h, expected no beat", i, pdv);
      end else begin
        w = (i == 0) ? qa[0] : (i == 1) ? qb[0] : qc[0];
        k = msb ? (r - 1 - bidx[i]) : bidx[i];
        e = (w >> (k * bw)) & ((32'h1 << bw) - 32'h1);
        chk($sformatf("rnd_beat_i%0d", i), pdv, e);
        chk($sformatf("rnd_last_i%0d", i), 32'(pl), 32'(bidx[i] == r - 1));
        bidx[i]++;
        if (bidx[i] == r) begin
          bidx[i] = 0;
          done[i]++;
          case (i)
            0: void'(qa.pop_front());
            1: void'(qb.pop_front());
            default: void'(qc.pop_front());
          endcase
        end
      end
    end
    if (cs && cdr) begin
      case (i)
        0: qa.push_back(cd);
        1: qb.push_back(cd);
        default: qc.push_back(cd);
      endcase
    end
  endtask

  typedef struct {
    logic       cs;
    logic [7:0] cdat;
    logic       pd;
    logic       e_ps;
    logic [3:0] e_pdat;
    logic       e_pl;
    logic       e_cd;
  } vec_t;

`ifdef SD_ENMUX_N_ZERO_BUBBLE_EN
  localparam int NV = 10;
`else
  localparam int NV = 11;
`endif
  vec_t vecs[NV];

  initial begin
    logic [7:0] dexp[4];
    logic [7:0] bexp[3];
    logic [7:0] rexp[4];
    logic acc_a, acc_b, acc_c;
    int sp, dp;

    a_cs = 0; a_cdat = '0; a_pd = 1;
    b_cs = 0; b_cdat = '0; b_pd = 1;
    c_cs = 0; c_cdat = '0; c_pd = 1;
    d_cs = 0; d_cdat = '0; d_pd = 1;
    for (int i = 0; i < 3; i++) begin
      bidx[i] = 0;
      done[i] = 0;
    end

    vecs[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 4'h5, 1'b0, 1'b0};
`ifdef SD_ENMUX_N_ZERO_BUBBLE_EN
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 4'hA, 1'b1, 1'b1};
`else
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 4'hA, 1'b1, 1'b0};
`endif
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'h5, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 8'h12, 1'b1, 1'b0, 4'h5, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 8'h34, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0};
`ifdef SD_ENMUX_N_ZERO_BUBBLE_EN
    vecs[6] = '{1'b1, 8'h34, 1'b1, 1'b1, 4'h1, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 4'h4, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 4'h3, 1'b1, 1'b1};
    vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'h4, 1'b0, 1'b1};
`else
    vecs[6] = '{1'b1, 8'h34, 1'b1, 1'b1, 4'h1, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 8'h34, 1'b1, 1'b0, 4'h2, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 4'h4, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b1, 4'h3, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'h4, 1'b0, 1'b1};
`endif

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_a_p_srdy", 32'(a_ps), 32'h0);
    chk("rst_a_p_last", 32'(a_pl), 32'h0);
    chk("rst_a_p_data", 32'(a_pdat), 32'h0);
    chk("rst_a_c_drdy", 32'(a_cd), 32'h1);
    chk("rst_d_c_drdy", 32'(d_cd), 32'h1);
    step();

    // Table: single word, then back-to-back words on the 8/2 instance
    for (int i = 0; i < NV; i++) begin
      a_cs = vecs[i].cs;
      a_cdat = vecs[i].cdat;
      a_pd = vecs[i].pd;
      @(negedge clk);
      chk($sformatf("vec%0d_p_srdy", i), 32'(a_ps), 32'(vecs[i].e_ps));
      chk($sformatf("vec%0d_p_data", i), 32'(a_pdat), 32'(vecs[i].e_pdat));
      chk($sformatf("vec%0d_p_last", i), 32'(a_pl), 32'(vecs[i].e_pl));
      chk($sformatf("vec%0d_c_drdy", i), 32'(a_cd), 32'(vecs[i].e_cd));
      step();
    end
    a_cs = 0;

    // msb-first 4:1
    dexp = '{8'h11, 8'h22, 8'h33, 8'h44};
    d_cs = 1; d_cdat = 32'h11223344; d_pd = 1;
    @(negedge clk);
    chk("msb_accept_c_drdy", 32'(d_cd), 32'h1);
    step();
    d_cs = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("msb_beat%0d_p_srdy", i), 32'(d_ps), 32'h1);
      chk($sformatf("msb_beat%0d_p_data", i), 32'(d_pdat), 32'(dexp[i]));
      chk($sformatf("msb_beat%0d_p_last", i), 32'(d_pl), 32'(i == 3));
`ifdef SD_ENMUX_N_ZERO_BUBBLE_EN
      chk($sformatf("msb_beat%0d_c_drdy", i), 32'(d_cd), 32'(i == 3));
`else
      chk($sformatf("msb_beat%0d_c_drdy", i), 32'(d_cd), 32'h0);
`endif
      step();
    end
    @(negedge clk);
    chk("msb_idle_p_srdy", 32'(d_ps), 32'h0);
    chk("msb_idle_c_drdy", 32'(d_cd), 32'h1);
    step();

    // Stall after beat 0 on lsb-first 4:1
    bexp = '{8'h33, 8'h22, 8'h11};
    b_cs = 1; b_cdat = 32'h11223344; b_pd = 1;
    step();
    b_cs = 0;
    @(negedge clk);
    chk("stall_beat0_p_data", 32'(b_pdat), 32'h44);
    step();
    b_pd = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_p_srdy", i), 32'(b_ps), 32'h1);
      chk($sformatf("stall%0d_p_data", i), 32'(b_pdat), 32'h33);
      chk($sformatf("stall%0d_p_last", i), 32'(b_pl), 32'h0);
      chk($sformatf("stall%0d_c_drdy", i), 32'(b_cd), 32'h0);
      step();
    end
    b_pd = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("resume%0d_p_data", i), 32'(b_pdat), 32'(bexp[i]));
      chk($sformatf("resume%0d_p_last", i), 32'(b_pl), 32'(i == 2));
      step();
    end
    @(negedge clk);
    chk("resume_idle_p_srdy", 32'(b_ps), 32'h0);
    step();

    // Reset mid-word discards the partial word
    b_cs = 1; b_cdat = 32'hCAFEF00D;
    step();
    b_cs = 0;
    @(negedge clk);
    chk("rstmid_beat0_p_data", 32'(b_pdat), 32'h0D);
    step();
    reset = 1;
    step();
    reset = 0;
    @(negedge clk);
    chk("rstmid_p_srdy", 32'(b_ps), 32'h0);
    chk("rstmid_c_drdy", 32'(b_cd), 32'h1);
    chk("rstmid_p_last", 32'(b_pl), 32'h0);
    chk("rstmid_p_data", 32'(b_pdat), 32'h0);
    step();
    rexp = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    b_cs = 1; b_cdat = 32'hDEADBEEF;
    step();
    b_cs = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d_p_srdy", i), 32'(b_ps), 32'h1);
      chk($sformatf("post_rst%0d_p_data", i), 32'(b_pdat), 32'(rexp[i]));
      chk($sformatf("post_rst%0d_p_last", i), 32'(b_pl), 32'(i == 3));
      step();
    end
    @(negedge clk);
    chk("post_rst_idle_p_srdy", 32'(b_ps), 32'h0);
    step();

    // Random srdy/drdy on ratios 2, 4, 8; an offered word is held until taken
    acc_a = 0; acc_b = 0; acc_c = 0;
    for (int cyc = 0; cyc < 24000; cyc++) begin
      if (cyc < 8000) begin
        sp = 95; dp = 95;
      end else if (cyc < 16000) begin
        sp = 50; dp = 50;
      end else begin
        sp = 90; dp = 30;
      end
      if (!a_cs || acc_a) begin
        a_cs = ($urandom_range(99) < sp);
        a_cdat = 8'($urandom);
      end
      if (!b_cs || acc_b) begin
        b_cs = ($urandom_range(99) < sp);
        b_cdat = $urandom;
      end
      if (!c_cs || acc_c) begin
        c_cs = ($urandom_range(99) < sp);
        c_cdat = $urandom;
      end
      a_pd = ($urandom_range(99) < dp);
      b_pd = ($urandom_range(99) < dp);
      c_pd = ($urandom_range(99) < dp);
      @(negedge clk);
      sb(0, a_cs, a_cd, 32'(a_cdat), a_ps, a_pd, 32'(a_pdat), a_pl);
      sb(1, b_cs, b_cd, b_cdat, b_ps, b_pd, 32'(b_pdat), b_pl);
      sb(2, c_cs, c_cd, c_cdat, c_ps, c_pd, 32'(c_pdat), c_pl);
      acc_a = a_cs & a_cd;
      acc_b = b_cs & b_cd;
      acc_c = c_cs & c_cd;
      step();
    end
    a_cs = 0; b_cs = 0; c_cs = 0;
    a_pd = 1; b_pd = 1; c_pd = 1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      sb(0, a_cs, a_cd, 32'(a_cdat), a_ps, a_pd, 32'(a_pdat), a_pl);
      sb(1, b_cs, b_cd, b_cdat, b_ps, b_pd, 32'(b_pdat), b_pl);
      sb(2, c_cs, c_cd, c_cdat, c_ps, c_pd, 32'(c_pdat), c_pl);
      step();
    end
    chk("rnd_drain_q_r2", 32'(qa.size()), 32'h0);
    chk("rnd_drain_q_r4", 32'(qb.size()), 32'h0);
    chk("rnd_drain_q_r8", 32'(qc.size()), 32'h0);
    chk("rnd_words_r2_ge1000", 32'(done[0] >= 1000), 32'h1);
    chk("rnd_words_r4_ge1000", 32'(done[1] >= 1000), 32'h1);
    chk("rnd_words_r8_ge1000", 32'(done[2] >= 1000), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
